divider_16_bit: RTL and testbench

- Multi-cycle restoring divider that consumes the team's subtractor_16_bit as its trial-subtract datapath, one quotient bit per clock.
- Sits in the ALU next to the adder/subtractor units. Takes 16-bit dividend/divisor on a start pulse and returns quotient, remainder and status flags after a fixed latency.
- Signed (two's complement) operation is optional (see Optional Feature); the core iterates on magnitudes.

---
 rtl/divider_16_bit.sv | 185 ++++++++++++++++++
 tb/tb_divider_16_bit.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/divider_16_bit.sv
// Multi-cycle restoring divider (16-bit); one quotient bit per clock through subtractor_16_bit.
// Define DIVIDER_SIGNED_EN for two's complement operands; the default build is unsigned.

module subtractor_16_bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] diff
);
  assign diff = a - b;
endmodule

module divider_16_bit #(
  parameter int WIDTH = 16,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter value that ends RUN; reached one cycle after the last quotient bit.
  localparam logic [4:0] LAST = 5'(ITER);

  state_t           state_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] orig_r;
  logic [4:0]       cnt_r;
  logic             dz_r;
  logic             ovf_r;

  logic [WIDTH:0]   partial_s;
  logic [WIDTH-1:0] trial_s;
  logic [WIDTH-1:0] rem_next_s;
  logic [WIDTH-1:0] mag_a_s;
  logic [WIDTH-1:0] mag_b_s;
  logic [WIDTH-1:0] q_cor_s;
  logic [WIDTH-1:0] r_cor_s;
  logic [WIDTH-1:0] q_fix_s;
  logic [WIDTH-1:0] r_fix_s;
  logic             ge_s;
  logic             accept_s;
  logic             ovf_next_s;

`ifdef DIVIDER_SIGNED_EN
  logic sign_q_r;
  logic sign_r_r;

  function automatic logic [15:0] neg16(input logic [15:0] x);
    logic [15:0] inv;
    inv = ~x;
    return inv + 16'h0001;
  endfunction
`endif

  // Trial subtraction of the divisor from the shifted partial remainder
  subtractor_16_bit u_sub (
    .a   (partial_s[15:0]),
    .b   (dsr_r),
    .diff(trial_s)
  );

  // Operand magnitudes, restoring step and final sign/zero correction
  always_comb begin
    accept_s  = start && ((state_r == IDLE) || (state_r == DONE));
    partial_s = {rem_r, quo_r[WIDTH-1]};
    ge_s      = (partial_s >= {1'b0, dsr_r});
    if (ge_s) begin
      rem_next_s = trial_s;
    end else begin
      rem_next_s = partial_s[WIDTH-1:0];
    end
`ifdef DIVIDER_SIGNED_EN
    if (dividend[15]) mag_a_s = neg16(dividend);
    else              mag_a_s = dividend;
    if (divisor[15])  mag_b_s = neg16(divisor);
    else              mag_b_s = divisor;
    ovf_next_s = (dividend == 16'h8000) && (divisor == 16'hFFFF);
    if (sign_q_r) q_cor_s = neg16(quo_r);
    else          q_cor_s = quo_r;
    if (sign_r_r) r_cor_s = neg16(rem_r);
    else          r_cor_s = rem_r;
`else
    mag_a_s    = dividend;
    mag_b_s    = divisor;
    ovf_next_s = 1'b0;
    q_cor_s    = quo_r;
    r_cor_s    = rem_r;
`endif
    // A zero divisor returns all-ones and hands back the untouched dividend.
    if (dz_r) begin
      q_fix_s = 16'hFFFF;
      r_fix_s = orig_r;
    end else begin
      q_fix_s = q_cor_s;
      r_fix_s = r_cor_s;
    end
  end

  // Control FSM, iteration registers and held results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      quo_r       <= 16'h0000;
      dsr_r       <= 16'h0000;
      rem_r       <= 16'h0000;
      orig_r      <= 16'h0000;
      cnt_r       <= 5'd0;
      dz_r        <= 1'b0;
      ovf_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= 16'h0000;
      remainder   <= 16'h0000;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE, DONE: begin
          if (accept_s) begin
            state_r <= RUN;
            busy    <= 1'b1;
            quo_r   <= mag_a_s;
            dsr_r   <= mag_b_s;
            rem_r   <= 16'h0000;
            orig_r  <= dividend;
            cnt_r   <= 5'd0;
            dz_r    <= (divisor == 16'h0000);
            ovf_r   <= ovf_next_s;
`ifdef DIVIDER_SIGNED_EN
            sign_q_r <= dividend[15] ^ divisor[15];
            sign_r_r <= dividend[15];
`endif
          end else begin
            state_r <= IDLE;
          end
        end
        RUN: begin
          if (cnt_r == LAST) begin
            state_r <= FIX;
          end else begin
            rem_r <= rem_next_s;
            quo_r <= {quo_r[WIDTH-2:0], ge_s};
            cnt_r <= cnt_r + 5'd1;
          end
        end
        FIX: begin
          state_r     <= DONE;
          busy        <= 1'b0;
          done        <= 1'b1;
          quotient    <= q_fix_s;
          remainder   <= r_fix_s;
          div_by_zero <= dz_r;
          overflow    <= ovf_r && !dz_r;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_16_bit.sv
// Directed, table-driven bench for divider_16_bit; hand-computed expected results.
// Signed vectors are selected when DIVIDER_SIGNED_EN is defined.

module tb_divider_16_bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] last_q = 16'h0000;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
  } vec_t;

  vec_t vecs[$];

  divider_16_bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [15:0] a, b, q, r, input logic dz, ov);
    vec_t v;
    v.a = a; v.b = b; v.q = q; v.r = r; v.dz = dz; v.ov = ov;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Counts edges until done; optionally pulses start with 9/3 at edge inj_at.
  task automatic wait_done(input string tag, input int inj_at, output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (lat == inj_at) begin
        start = 1'b1; dividend = 16'd9; divisor = 16'd3;
      end else begin
        start = 1'b0;
      end
      if (lat == 5) begin
        check({tag, "_busy_mid"}, busy, 1);
        check({tag, "_held_q"}, quotient, last_q);
      end
    end
  endtask

  task automatic check_result(input string tag, input vec_t v, input int lat);
    check({tag, "_latency"}, lat, 18);
    check({tag, "_done"}, done, 1);
    check({tag, "_q"}, quotient, v.q);
    check({tag, "_r"}, remainder, v.r);
    check({tag, "_dz"}, div_by_zero, v.dz);
    check({tag, "_ov"}, overflow, v.ov);
    check({tag, "_busy_end"}, busy, 0);
    last_q = v.q;
  endtask

  task automatic accept(input logic [15:0] a, b);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'h5555; divisor = 16'h0003;
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    accept(v.a, v.b);
    check({tag, "_busy"}, busy, 1);
    wait_done(tag, -1, lat);
    check_result(tag, v, lat);
    @(posedge clk); #1;
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int lat;
    int seen;
    vec_t v;

    vecs.push_back(mk(16'd100,  16'd7,   16'h000E, 16'h0002, 1'b0, 1'b0));
    vecs.push_back(mk(16'd1234, 16'd0,   16'hFFFF, 16'd1234, 1'b1, 1'b0));
    vecs.push_back(mk(16'd0,    16'd5,   16'h0000, 16'h0000, 1'b0, 1'b0));
    vecs.push_back(mk(16'd7,    16'd100, 16'h0000, 16'h0007, 1'b0, 1'b0));
    vecs.push_back(mk(16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0));
`ifdef DIVIDER_SIGNED_EN
    vecs.push_back(mk(16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0));
    vecs.push_back(mk(16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0));
    vecs.push_back(mk(16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1));
    vecs.push_back(mk(16'hFFFF, 16'h0002, 16'h0000, 16'hFFFF, 1'b0, 1'b0));
    vecs.push_back(mk(16'hFFFB, 16'h0000, 16'hFFFF, 16'hFFFB, 1'b1, 1'b0));
`else
    vecs.push_back(mk(16'hFFFF, 16'h0002, 16'h7FFF, 16'h0001, 1'b0, 1'b0));
    vecs.push_back(mk(16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0));
    vecs.push_back(mk(16'hFFFB, 16'h0000, 16'hFFFF, 16'hFFFB, 1'b1, 1'b0));
`endif

    rst_n = 1'b0; start = 1'b0; dividend = 16'h0000; divisor = 16'h0000;
    #1;
    check("rst_q", quotient, 16'h0000);
    check("rst_r", remainder, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_flags", {div_by_zero, overflow}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_done", done, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec($sformatf("v%0d", i), vecs[i]);
    end

    // Start during RUN is ignored, then a back-to-back start in the DONE cycle.
    accept(16'd50, 16'd5);
    wait_done("ign", 4, lat);
    check_result("ign", mk(16'd50, 16'd5, 16'd10, 16'd0, 1'b0, 1'b0), lat);
    dividend = 16'd9; divisor = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'hAAAA; divisor = 16'h0001;
    check("b2b_busy", busy, 1);
    check("b2b_done_low", done, 0);
    wait_done("b2b", -1, lat);
    check_result("b2b", mk(16'd9, 16'd3, 16'd3, 16'd0, 1'b0, 1'b0), lat);

    // Asynchronous reset in the middle of RUN aborts with no done pulse.
    accept(16'd3000, 16'd7);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", quotient, 16'h0000);
    check("arst_r", remainder, 16'h0000);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    last_q = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("arst_no_done", seen, 0);
    v = mk(16'd1000, 16'd10, 16'd100, 16'd0, 1'b0, 1'b0);
    run_vec("post_rst", v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
